gem_tx_link_seq: RTL and testbench
==================================

// Module: gem_tx_link_seq
// PURPOSE
//  Bring-up and supervision sequencer for the GEM trigger-fiber transmitter.
//  - Drives the TX PLL reset, the GTX TX reset and the datapath reset (TRG_RST, sends 50BC idles) in order.
//  - Waits for PLL lock, TX reset done and TX phase-sync done, then sends a fixed run of idle frames.
//  - After the idle run it declares the link up and supplies the rotating frame-separator K-code.
//  - While up it watches link health and restarts the whole sequence on a fault or on request.
// PARAMETERS
//  PLLRST_CYCLES  16     cycles TRG_TX_PLLRST is held high (>=1)
//  GTXRST_CYCLES  16     cycles TRG_GTXTXRST is held high alone (>=1)
//  LOCK_TIMEOUT   65535  max cycles in any WAIT_* state (16-bit)
//  IDLE_FRAMES    64     idle frames (2 clocks each) sent with TRG_RST high before link-up (>=1)
// PORTS
//  TRG_CLK80      in   1  80 MHz frame clock; the only clock
//  RST            in   1  synchronous, active-high reset
//  TX_PLL_LOCK    in   1  GTX TX PLL lock detect (async; 2-flop synced inside)
//  TXRESETDONE    in   1  GTX TX reset done (async; 2-flop synced inside)
//  TX_SYNC_DONE   in   1  phase-alignment done (async; 2-flop synced inside)
//  FORCE_RESYNC   in   1  single-cycle request to restart the sequence
//  TRG_TX_PLLRST  out  1  TX PLL reset
//  TRG_GTXTXRST   out  1  GTX TX reset
//  TRG_RST        out  1  datapath reset (idle K-codes while high)
//  LINK_UP        out  1  link operational
//  FRM_SEP        out  8  frame separator K-code: BC/F7/FB/FD
//  RESYNC_CNT     out  8  restarts taken from LINK_UP, saturates at 255
//  TIMEOUT_ERR    out  1  sticky: some WAIT_* state timed out
//  STATE          out  3  current FSM state, for monitoring
// BEHAVIOUR
//  Output timing and reset
//  - All outputs are registered and are a function of the current state.
//  - On RST: STATE=PLLRST, cnt=0, TRG_TX_PLLRST=1, TRG_GTXTXRST=1, TRG_RST=1,
//    LINK_UP=0, FRM_SEP=8'hBC, RESYNC_CNT=0, TIMEOUT_ERR=0.
//  - RST has priority over every other event.
//  Counter and input sync
//  - cnt is 16 bits. It clears on every state change and increments each cycle otherwise.
//  - lock_s, done_s and sync_s are the synced inputs. Each adds 2 cycles of latency.
//  FSM (entries are: code name: outputs PLLRST/GTXRST/TRG_RST; transitions)
//  - 0 PLLRST: 1/1/1. When cnt==PLLRST_CYCLES-1, go to WAIT_LOCK.
//  - 1 WAIT_LOCK: 0/1/1. lock_s=1 -> GTXRST. Else if cnt==LOCK_TIMEOUT -> PLLRST and set TIMEOUT_ERR.
//  - 2 GTXRST: 0/1/1. When cnt==GTXRST_CYCLES-1, go to WAIT_DONE.
//    lock_s=0 here -> PLLRST.
//  - 3 WAIT_DONE: 0/0/1. done_s=1 -> WAIT_SYNC. Timeout -> PLLRST and set TIMEOUT_ERR.
//  - 4 WAIT_SYNC: 0/0/1. sync_s=1 -> IDLE. Timeout -> PLLRST and set TIMEOUT_ERR.
//  - 5 IDLE: 0/0/1. When cnt==2*IDLE_FRAMES-1, go to UP.
//  - 6 UP: 0/0/0, LINK_UP=1.
//    - Fault exit: lock_s=0, done_s=0 or FORCE_RESYNC -> PLLRST,
//      with RESYNC_CNT+1 (saturating at 255).
//    - In states 1-5, lock_s=0 (except state 1) or FORCE_RESYNC -> PLLRST without counting.
//    - FORCE_RESYNC in PLLRST is ignored; cnt is not cleared.
//  Frame-separator rotation
//  - phase bit clears on entry to UP and toggles every cycle while in UP.
//  - On each cycle with phase==1, FRM_SEP advances BC->F7->FB->FD->BC.
//  - On leaving UP, FRM_SEP returns to BC and holds there until the next UP.
//  Simultaneous events
//  - A fault on the same cycle as a timeout: counts as one PLLRST entry, and TIMEOUT_ERR is set.
//  - A fault in UP on the same cycle as the FRM_SEP advance: exit wins, so FRM_SEP=BC.
//  - TIMEOUT_ERR clears only on RST.
// TESTING (PLLRST_CYCLES=4, GTXRST_CYCLES=4, LOCK_TIMEOUT=100, IDLE_FRAMES=2)
//  1 Nominal bring-up. All three status inputs go high one cycle after each is enabled.
//    -> PLLRST high 4 cycles; GTXRST released; TRG_RST falls after 4 IDLE cycles.
//    -> LINK_UP=1; FRM_SEP=BC,BC,F7,F7,FB,FB,FD,FD,BC.
//  2 TX_PLL_LOCK held low -> after 101 WAIT_LOCK cycles: STATE=0 and TIMEOUT_ERR=1.
//    TIMEOUT_ERR stays 1 through the next successful bring-up.
//  3 Drop TX_PLL_LOCK for 1 cycle in UP -> PLLRST 3 cycles later.
//    -> LINK_UP=0, TRG_RST=1, FRM_SEP=BC, RESYNC_CNT=1.
//  4 FORCE_RESYNC in WAIT_SYNC -> PLLRST, RESYNC_CNT unchanged.
//    FORCE_RESYNC in PLLRST -> no effect.
//  5 256 forced resyncs from UP -> RESYNC_CNT stays 255.
//  6 RST asserted in IDLE and in UP -> next cycle: every output at its reset value.

Source files
------------

// File: rtl/gem_tx_link_seq_if.sv
// ---------------------------------------------------------------------------
// gem_tx_link_seq_if
//   Bundles the GEM trigger-fiber TX sequencer's status inputs, control
//   outputs and monitoring outputs into one port.
//
//   master : the sequencer itself. It reads the transceiver status and the
//            resync request, and drives the resets, link status, K-code and
//            monitoring counters.
//   slave  : the transceiver/control side. It drives the status and the
//            request, and observes everything else.
//
//   Signals
//     TX_PLL_LOCK   GTX TX PLL lock detect (asynchronous)
//     TXRESETDONE   GTX TX reset done (asynchronous)
//     TX_SYNC_DONE  TX phase-alignment done (asynchronous)
//     FORCE_RESYNC  single-cycle request to restart bring-up (synchronous)
//     TRG_TX_PLLRST TX PLL reset
//     TRG_GTXTXRST  GTX TX reset
//     TRG_RST       datapath reset (idle K-codes while high)
//     LINK_UP       link operational
//     FRM_SEP[7:0]  rotating frame-separator K-code
//     RESYNC_CNT    restarts taken from LINK_UP, saturating
//     TIMEOUT_ERR   sticky wait-state timeout flag
//     STATE[2:0]    current sequencer state
// ---------------------------------------------------------------------------
interface gem_tx_link_seq_if;
    logic       TX_PLL_LOCK;
    logic       TXRESETDONE;
    logic       TX_SYNC_DONE;
    logic       FORCE_RESYNC;
    logic       TRG_TX_PLLRST;
    logic       TRG_GTXTXRST;
    logic       TRG_RST;
    logic       LINK_UP;
    logic [7:0] FRM_SEP;
    logic [7:0] RESYNC_CNT;
    logic       TIMEOUT_ERR;
    logic [2:0] STATE;

    modport master (
        input  TX_PLL_LOCK, TXRESETDONE, TX_SYNC_DONE, FORCE_RESYNC,
        output TRG_TX_PLLRST, TRG_GTXTXRST, TRG_RST, LINK_UP,
        output FRM_SEP, RESYNC_CNT, TIMEOUT_ERR, STATE
    );

    modport slave (
        output TX_PLL_LOCK, TXRESETDONE, TX_SYNC_DONE, FORCE_RESYNC,
        input  TRG_TX_PLLRST, TRG_GTXTXRST, TRG_RST, LINK_UP,
        input  FRM_SEP, RESYNC_CNT, TIMEOUT_ERR, STATE
    );
endinterface

// File: rtl/gem_tx_link_seq.sv
// ---------------------------------------------------------------------------
// gem_tx_link_seq
//   Bring-up and supervision sequencer for the GEM trigger-fiber transmitter.
//   Walks PLL reset -> wait lock -> GTX reset -> wait reset done -> wait
//   phase sync -> idle run -> link up, and restarts from PLL reset on a
//   health fault, a timeout or a FORCE_RESYNC request.
//
//   Ports
//     TRG_CLK80  80 MHz frame clock, the only clock
//     RST        synchronous, active-high reset
//     bus        gem_tx_link_seq_if.master (status in, resets/status out)
//
//   Parameters
//     PLLRST_CYCLES  cycles TRG_TX_PLLRST is held high (>=1)
//     GTXRST_CYCLES  cycles TRG_GTXTXRST is held high alone (>=1)
//     LOCK_TIMEOUT   max cycles spent in any WAIT_* state (16-bit)
//     IDLE_FRAMES    idle frames (2 clocks each) sent before link-up (>=1)
//
//   All outputs are registered decodes of the state being entered, so on
//   every cycle they match STATE exactly.
// ---------------------------------------------------------------------------
module gem_tx_link_seq #(
    parameter int PLLRST_CYCLES = 16,
    parameter int GTXRST_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int IDLE_FRAMES   = 64
) (
    input  logic               TRG_CLK80,
    input  logic               RST,
    gem_tx_link_seq_if.master  bus
);

    typedef enum logic [2:0] {
        S_PLLRST    = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_GTXRST    = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_WAIT_SYNC = 3'd4,
        S_IDLE      = 3'd5,
        S_UP        = 3'd6
    } state_t;

    localparam logic [15:0] PLLRST_LAST  = 16'(PLLRST_CYCLES - 1);
    localparam logic [15:0] GTXRST_LAST  = 16'(GTXRST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT);
    localparam logic [15:0] IDLE_LAST    = 16'(2 * IDLE_FRAMES - 1);

    localparam logic [7:0] K_BC = 8'hBC;
    localparam logic [7:0] K_F7 = 8'hF7;
    localparam logic [7:0] K_FB = 8'hFB;
    localparam logic [7:0] K_FD = 8'hFD;

    // Saturating increment for the restart counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Frame-separator rotation BC -> F7 -> FB -> FD -> BC.
    function automatic logic [7:0] frm_sep_next(input logic [7:0] v);
        logic [7:0] r;
        case (v)
            K_BC:    r = K_F7;
            K_F7:    r = K_FB;
            K_FB:    r = K_FD;
            default: r = K_BC;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;
    logic [7:0]  frm_sep_q, frm_sep_d;
    logic [7:0]  resync_cnt_q, resync_cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic        pllrst_q, pllrst_d;
    logic        gtxrst_q, gtxrst_d;
    logic        trg_rst_q, trg_rst_d;
    logic        link_up_q, link_up_d;

    // Two-flop synchronisers, bit 0 lock, bit 1 reset done, bit 2 sync done.
    logic [2:0]  meta_q, meta_d;
    logic [2:0]  sync_q, sync_d;

    logic        lock_s, done_s, sync_s;
    logic        tmo;
    logic        fault;
    logic        timeout_hit;
    logic        up_exit;

    assign lock_s = sync_q[0];
    assign done_s = sync_q[1];
    assign sync_s = sync_q[2];

    always_comb begin
        meta_d = {bus.TX_SYNC_DONE, bus.TXRESETDONE, bus.TX_PLL_LOCK};
        sync_d = meta_q;
    end

    // ---- state register --------------------------------------------------
    always_ff @(posedge TRG_CLK80) begin
        if (RST) begin
            meta_q        <= 3'b000;
            sync_q        <= 3'b000;
            state_q       <= S_PLLRST;
            cnt_q         <= 16'd0;
            phase_q       <= 1'b0;
            frm_sep_q     <= K_BC;
            resync_cnt_q  <= 8'd0;
            timeout_err_q <= 1'b0;
            pllrst_q      <= 1'b1;
            gtxrst_q      <= 1'b1;
            trg_rst_q     <= 1'b1;
            link_up_q     <= 1'b0;
        end else begin
            meta_q        <= meta_d;
            sync_q        <= sync_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            phase_q       <= phase_d;
            frm_sep_q     <= frm_sep_d;
            resync_cnt_q  <= resync_cnt_d;
            timeout_err_q <= timeout_err_d;
            pllrst_q      <= pllrst_d;
            gtxrst_q      <= gtxrst_d;
            trg_rst_q     <= trg_rst_d;
            link_up_q     <= link_up_d;
        end
    end

    // ---- next-state logic ------------------------------------------------
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        up_exit     = 1'b0;
        tmo         = (cnt_q == TIMEOUT_LAST);
        // Loss of lock or a restart request aborts any state past WAIT_LOCK.
        fault       = !lock_s || bus.FORCE_RESYNC;

        case (state_q)
            S_PLLRST: begin
                // FORCE_RESYNC is deliberately ignored: already restarting.
                if (cnt_q == PLLRST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock is what is being waited for, so only the request aborts.
                timeout_hit = tmo && !lock_s;
                if (bus.FORCE_RESYNC) state_d = S_PLLRST;
                else if (lock_s)      state_d = S_GTXRST;
                else if (tmo)         state_d = S_PLLRST;
            end
            S_GTXRST: begin
                if (fault)                    state_d = S_PLLRST;
                else if (cnt_q == GTXRST_LAST) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // A timeout coinciding with a fault still flags the error.
                timeout_hit = tmo && !done_s;
                if (fault)       state_d = S_PLLRST;
                else if (done_s) state_d = S_WAIT_SYNC;
                else if (tmo)    state_d = S_PLLRST;
            end
            S_WAIT_SYNC: begin
                timeout_hit = tmo && !sync_s;
                if (fault)       state_d = S_PLLRST;
                else if (sync_s) state_d = S_IDLE;
                else if (tmo)    state_d = S_PLLRST;
            end
            S_IDLE: begin
                if (fault)                   state_d = S_PLLRST;
                else if (cnt_q == IDLE_LAST) state_d = S_UP;
            end
            S_UP: begin
                if (fault || !done_s) begin
                    state_d = S_PLLRST;
                    up_exit = 1'b1;
                end
            end
            default: state_d = S_PLLRST;
        endcase

        cnt_d = (state_d != state_q) ? 16'd0 : cnt_q + 16'd1;

        // Phase starts at 0 on the first UP cycle and toggles while staying up.
        phase_d = (state_q == S_UP && state_d == S_UP) ? ~phase_q : 1'b0;

        // Leaving (or not being in) UP forces BC, which also wins over an advance.
        if (state_d != S_UP)
            frm_sep_d = K_BC;
        else if (state_q == S_UP && phase_q)
            frm_sep_d = frm_sep_next(frm_sep_q);
        else
            frm_sep_d = frm_sep_q;

        resync_cnt_d  = up_exit ? sat_inc8(resync_cnt_q) : resync_cnt_q;
        timeout_err_d = timeout_err_q | timeout_hit;
    end

    // ---- output decode of the state being entered -------------------------
    always_comb begin
        pllrst_d  = 1'b1;
        gtxrst_d  = 1'b1;
        trg_rst_d = 1'b1;
        link_up_d = 1'b0;
        case (state_d)
            S_PLLRST: begin
                pllrst_d = 1'b1;
                gtxrst_d = 1'b1;
            end
            S_WAIT_LOCK, S_GTXRST: begin
                pllrst_d = 1'b0;
                gtxrst_d = 1'b1;
            end
            S_WAIT_DONE, S_WAIT_SYNC, S_IDLE: begin
                pllrst_d = 1'b0;
                gtxrst_d = 1'b0;
            end
            S_UP: begin
                pllrst_d  = 1'b0;
                gtxrst_d  = 1'b0;
                trg_rst_d = 1'b0;
                link_up_d = 1'b1;
            end
            default: begin
                pllrst_d = 1'b1;
                gtxrst_d = 1'b1;
            end
        endcase
    end

    assign bus.TRG_TX_PLLRST = pllrst_q;
    assign bus.TRG_GTXTXRST  = gtxrst_q;
    assign bus.TRG_RST       = trg_rst_q;
    assign bus.LINK_UP       = link_up_q;
    assign bus.FRM_SEP       = frm_sep_q;
    assign bus.RESYNC_CNT    = resync_cnt_q;
    assign bus.TIMEOUT_ERR   = timeout_err_q;
    assign bus.STATE         = state_q;

endmodule

// File: tb/tb_gem_tx_link_seq.sv
// ---------------------------------------------------------------------------
// tb_gem_tx_link_seq
//   Directed bench for gem_tx_link_seq with short timing parameters.
//   A table of {inputs, cycles, expected outputs} covers nominal bring-up,
//   frame-separator rotation and a forced restart; hand-written sequences
//   cover timeout, lock loss in UP, resync corner cases, counter saturation
//   and reset from IDLE/UP.
// ---------------------------------------------------------------------------
module tb_gem_tx_link_seq;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gem_tx_link_seq_if ifc ();

    gem_tx_link_seq #(
        .PLLRST_CYCLES(4),
        .GTXRST_CYCLES(4),
        .LOCK_TIMEOUT (100),
        .IDLE_FRAMES  (2)
    ) dut (
        .TRG_CLK80(clk),
        .RST      (rst),
        .bus      (ifc)
    );

    typedef struct {
        logic       lock;
        logic       done;
        logic       sync;
        logic       frc;
        int         n;
        int         st;
        logic       pll;
        logic       gtx;
        logic       trst;
        logic       lu;
        logic [7:0] frm;
        int         rcnt;
        logic       te;
    } vec_t;

    vec_t tbl[$];
    int   n_chk;
    int   n_fail;

    function automatic void add(logic l, logic d, logic s, logic f, int n, int st,
                                logic p, logic g, logic t, logic u,
                                logic [7:0] fr, int rc, logic te);
        vec_t v;
        v.lock = l; v.done = d; v.sync = s; v.frc = f; v.n = n; v.st = st;
        v.pll = p; v.gtx = g; v.trst = t; v.lu = u; v.frm = fr; v.rcnt = rc; v.te = te;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(logic l, logic d, logic s, logic f);
        ifc.TX_PLL_LOCK  = l;
        ifc.TXRESETDONE  = d;
        ifc.TX_SYNC_DONE = s;
        ifc.FORCE_RESYNC = f;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic check_reset(string tag);
        chk({tag, ".state"},  int'(ifc.STATE),         0);
        chk({tag, ".pllrst"}, int'(ifc.TRG_TX_PLLRST), 1);
        chk({tag, ".gtxrst"}, int'(ifc.TRG_GTXTXRST),  1);
        chk({tag, ".trgrst"}, int'(ifc.TRG_RST),       1);
        chk({tag, ".linkup"}, int'(ifc.LINK_UP),       0);
        chk({tag, ".frmsep"}, int'(ifc.FRM_SEP),       8'hBC);
        chk({tag, ".rcnt"},   int'(ifc.RESYNC_CNT),    0);
        chk({tag, ".tmoerr"}, int'(ifc.TIMEOUT_ERR),   0);
    endtask

    task automatic check_vec(int i, vec_t v);
        string t;
        t = $sformatf("vec%0d", i);
        chk({t, ".state"},  int'(ifc.STATE),         v.st);
        chk({t, ".pllrst"}, int'(ifc.TRG_TX_PLLRST), int'(v.pll));
        chk({t, ".gtxrst"}, int'(ifc.TRG_GTXTXRST),  int'(v.gtx));
        chk({t, ".trgrst"}, int'(ifc.TRG_RST),       int'(v.trst));
        chk({t, ".linkup"}, int'(ifc.LINK_UP),       int'(v.lu));
        chk({t, ".frmsep"}, int'(ifc.FRM_SEP),       int'(v.frm));
        chk({t, ".rcnt"},   int'(ifc.RESYNC_CNT),    v.rcnt);
        chk({t, ".tmoerr"}, int'(ifc.TIMEOUT_ERR),   int'(v.te));
    endtask

    // Bounded wait for a state; running out of budget is a failed comparison.
    task automatic wait_state(string name, int st, int budget);
        int k;
        k = 0;
        while (int'(ifc.STATE) != st && k < budget) begin
            step(1);
            k++;
        end
        chk(name, int'(ifc.STATE), st);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);

        // Nominal bring-up with status held high, counted in edges after reset.
        //   lock done sync frc  n  st pll gtx trst lu frm    rc te
        add(1, 1, 1, 0, 3, 0, 1, 1, 1, 0, 8'hBC, 0, 0); // last PLLRST cycle
        add(1, 1, 1, 0, 1, 1, 0, 1, 1, 0, 8'hBC, 0, 0); // WAIT_LOCK
        add(1, 1, 1, 0, 1, 2, 0, 1, 1, 0, 8'hBC, 0, 0); // GTXRST
        add(1, 1, 1, 0, 4, 3, 0, 0, 1, 0, 8'hBC, 0, 0); // WAIT_DONE
        add(1, 1, 1, 0, 1, 4, 0, 0, 1, 0, 8'hBC, 0, 0); // WAIT_SYNC
        add(1, 1, 1, 0, 1, 5, 0, 0, 1, 0, 8'hBC, 0, 0); // IDLE first
        add(1, 1, 1, 0, 3, 5, 0, 0, 1, 0, 8'hBC, 0, 0); // IDLE fourth
        add(1, 1, 1, 0, 1, 6, 0, 0, 0, 1, 8'hBC, 0, 0); // UP 1
        add(1, 1, 1, 0, 1, 6, 0, 0, 0, 1, 8'hBC, 0, 0); // UP 2
        add(1, 1, 1, 0, 1, 6, 0, 0, 0, 1, 8'hF7, 0, 0); // UP 3
        add(1, 1, 1, 0, 1, 6, 0, 0, 0, 1, 8'hF7, 0, 0); // UP 4
        add(1, 1, 1, 0, 1, 6, 0, 0, 0, 1, 8'hFB, 0, 0); // UP 5
        add(1, 1, 1, 0, 2, 6, 0, 0, 0, 1, 8'hFD, 0, 0); // UP 7
        add(1, 1, 1, 0, 1, 6, 0, 0, 0, 1, 8'hFD, 0, 0); // UP 8
        add(1, 1, 1, 0, 1, 6, 0, 0, 0, 1, 8'hBC, 0, 0); // UP 9
        add(1, 1, 1, 1, 1, 0, 1, 1, 1, 0, 8'hBC, 1, 0); // forced restart from UP
        add(1, 1, 1, 0, 3, 0, 1, 1, 1, 0, 8'hBC, 1, 0); // PLLRST still 4 cycles
        add(1, 1, 1, 0, 1, 1, 0, 1, 1, 0, 8'hBC, 1, 0); // then WAIT_LOCK

        do_reset();
        check_reset("reset");

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].lock, tbl[i].done, tbl[i].sync, tbl[i].frc);
            step(tbl[i].n);
            check_vec(i, tbl[i]);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0);

        // Lock never arrives: 101 cycles in WAIT_LOCK, then timeout.
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        step(104);
        chk("tmo.still_waiting", int'(ifc.STATE), 1);
        chk("tmo.err_not_yet",   int'(ifc.TIMEOUT_ERR), 0);
        step(1);
        chk("tmo.state",  int'(ifc.STATE), 0);
        chk("tmo.err",    int'(ifc.TIMEOUT_ERR), 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        wait_state("tmo.reach_up", 6, 200);
        chk("tmo.err_sticky", int'(ifc.TIMEOUT_ERR), 1);
        chk("tmo.linkup",     int'(ifc.LINK_UP), 1);

        // One-cycle lock drop in UP: restart three edges later, counted.
        step(2);
        ifc.TX_PLL_LOCK = 1'b0;
        step(1);
        ifc.TX_PLL_LOCK = 1'b1;
        step(1);
        chk("drop.still_up", int'(ifc.STATE), 6);
        step(1);
        chk("drop.state",  int'(ifc.STATE), 0);
        chk("drop.linkup", int'(ifc.LINK_UP), 0);
        chk("drop.trgrst", int'(ifc.TRG_RST), 1);
        chk("drop.frmsep", int'(ifc.FRM_SEP), 8'hBC);
        chk("drop.rcnt",   int'(ifc.RESYNC_CNT), 1);

        // FORCE_RESYNC in WAIT_SYNC: restart without counting.
        ifc.TX_SYNC_DONE = 1'b0;
        wait_state("frc.reach_wsync", 4, 100);
        ifc.FORCE_RESYNC = 1'b1;
        step(1);
        ifc.FORCE_RESYNC = 1'b0;
        chk("frc.wsync_state", int'(ifc.STATE), 0);
        chk("frc.wsync_rcnt",  int'(ifc.RESYNC_CNT), 1);
        // FORCE_RESYNC in PLLRST must not stretch the PLL reset.
        ifc.TX_SYNC_DONE = 1'b1;
        step(1);
        ifc.FORCE_RESYNC = 1'b1;
        step(1);
        ifc.FORCE_RESYNC = 1'b0;
        chk("frc.pllrst_hold", int'(ifc.STATE), 0);
        step(1);
        chk("frc.pllrst_last", int'(ifc.STATE), 0);
        step(1);
        chk("frc.pllrst_exit", int'(ifc.STATE), 1);

        // 256 forced restarts from UP: counter saturates at 255.
        for (int r = 0; r < 256; r++) begin
            wait_state("sat.reach_up", 6, 100);
            ifc.FORCE_RESYNC = 1'b1;
            step(1);
            ifc.FORCE_RESYNC = 1'b0;
        end
        chk("sat.rcnt", int'(ifc.RESYNC_CNT), 255);

        // RST in IDLE and in UP.
        wait_state("rst.reach_idle", 5, 100);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_reset("rst_idle");
        wait_state("rst.reach_up", 6, 100);
        step(3);
        chk("rst.frm_before", int'(ifc.FRM_SEP), 8'hF7);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_reset("rst_up");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
